// File: rtl/wb_rf_wport_arbiter.sv
// wb_rf_wport_arbiter: schedules in-order writeback lanes and buffered
// long-latency results onto the register-file write ports.
// Optional performance counters are enabled with WPORT_ARB_PERF_CNT_EN.
module wb_rf_wport_arbiter #(
    parameter int unsigned ISSUE_WIDTH  = 2,
    parameter int unsigned WPORTS       = 2,
    parameter int unsigned LATE_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ISSUE_WIDTH-1:0]    wb_we_i,
    input  logic [ISSUE_WIDTH*5-1:0]  wb_waddr_i,
    input  logic [ISSUE_WIDTH*32-1:0] wb_wdata_i,
    input  logic                      late_valid_i,
    output logic                      late_ready_o,
    input  logic [4:0]                late_waddr_i,
    input  logic [31:0]               late_wdata_i,
    output logic [WPORTS-1:0]         rf_we_o,
    output logic [WPORTS*5-1:0]       rf_waddr_o,
    output logic [WPORTS*32-1:0]      rf_wdata_o,
    output logic                      pause_req_o,
    output logic                      busy_o
`ifdef WPORT_ARB_PERF_CNT_EN
   ,output logic [31:0]               perf_pause_cycles_o,
    output logic [31:0]               perf_late_writes_o
`endif
);

    localparam int unsigned PW = (LATE_DEPTH > 1) ? $clog2(LATE_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {ST_RUN, ST_PAUSE} state_e;

    state_e                  state_q, state_d;
    logic [SW-1:0]           starve_q, starve_d;
    logic [4:0]              fifo_addr_q [LATE_DEPTH];
    logic [4:0]              fifo_addr_d [LATE_DEPTH];
    logic [31:0]             fifo_data_q [LATE_DEPTH];
    logic [31:0]             fifo_data_d [LATE_DEPTH];
    logic [PW-1:0]           head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]           count_q, count_d;
    logic [WPORTS-1:0]       rf_we_q, rf_we_d;
    logic [WPORTS*5-1:0]     rf_waddr_q, rf_waddr_d;
    logic [WPORTS*32-1:0]    rf_wdata_q, rf_wdata_d;
    logic [ISSUE_WIDTH-1:0]  lane_valid;
    logic [CW-1:0]           n_pop;
    logic                    push;
`ifdef WPORT_ARB_PERF_CNT_EN
    logic [CW-1:0]           n_late_wr;
    logic [31:0]             perf_pause_q, perf_pause_d;
    logic [31:0]             perf_late_q, perf_late_d;
    logic [32:0]             perf_late_sum;
`endif

    assign late_ready_o = (count_q < CW'(LATE_DEPTH));
    assign busy_o       = (count_q != '0);
    assign pause_req_o  = (state_q == ST_PAUSE);
    assign rf_we_o      = rf_we_q;
    assign rf_waddr_o   = rf_waddr_q;
    assign rf_wdata_o   = rf_wdata_q;

    // Port allocation: valid lanes first in lane order, then FIFO head entries.
    // Port p takes the p-th valid lane; ports past the lanes take entry (p - n_lane).
    always_comb begin
        int unsigned n_lane;
        int unsigned seen;
        logic [PW-1:0] idx;
        logic hit;
        n_lane     = 0;
        seen       = 0;
        idx        = '0;
        hit        = 1'b0;
        lane_valid = '0;
        rf_we_d    = '0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        n_pop      = '0;
`ifdef WPORT_ARB_PERF_CNT_EN
        n_late_wr  = '0;
`endif
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            lane_valid[i] = wb_we_i[i] && (wb_waddr_i[i*5 +: 5] != 5'd0) && (state_q == ST_RUN);
            if (lane_valid[i]) n_lane = n_lane + 1;
        end
        for (int unsigned p = 0; p < WPORTS; p++) begin
            seen = 0;
            for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
                if (lane_valid[i]) begin
                    if (seen == p) begin
                        rf_we_d[p]            = 1'b1;
                        rf_waddr_d[p*5 +: 5]  = wb_waddr_i[i*5 +: 5];
                        rf_wdata_d[p*32 +: 32] = wb_wdata_i[i*32 +: 32];
                    end
                    seen = seen + 1;
                end
            end
            if ((p >= n_lane) && ((p - n_lane) < 32'(count_q))) begin
                idx = head_q + PW'(p - n_lane);
                hit = 1'b0;
                // A same-cycle lane write to the same register is younger: drop the entry.
                for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
                    if (lane_valid[i] && (wb_waddr_i[i*5 +: 5] == fifo_addr_q[idx])) hit = 1'b1;
                end
                if (!hit) begin
                    rf_we_d[p]             = 1'b1;
                    rf_waddr_d[p*5 +: 5]   = fifo_addr_q[idx];
                    rf_wdata_d[p*32 +: 32] = fifo_data_q[idx];
`ifdef WPORT_ARB_PERF_CNT_EN
                    n_late_wr = n_late_wr + CW'(1);
`endif
                end
                n_pop = n_pop + CW'(1);
            end
        end
    end

    // FIFO bookkeeping, starvation counter and pause state next-values.
    always_comb begin
        push        = late_valid_i && late_ready_o && (late_waddr_i != 5'd0);
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        if (push) begin
            fifo_addr_d[tail_q] = late_waddr_i;
            fifo_data_d[tail_q] = late_wdata_i;
        end
        tail_d   = push ? (tail_q + PW'(1)) : tail_q;
        head_d   = head_q + n_pop[PW-1:0];
        count_d  = count_q + CW'(push) - n_pop;
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            ST_RUN: begin
                if (starve_q >= SW'(STARVE_LIMIT)) begin
                    state_d  = ST_PAUSE;
                    starve_d = '0;
                end else if ((count_q == '0) || (n_pop != '0)) begin
                    starve_d = '0;
                end else begin
                    starve_d = starve_q + SW'(1);
                end
            end
            ST_PAUSE: begin
                starve_d = '0;
                if (count_q == '0) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        fifo_addr_q <= fifo_addr_d;
        fifo_data_q <= fifo_data_d;
        if (rst) begin
            state_q    <= ST_RUN;
            starve_q   <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rf_we_q    <= '0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

`ifdef WPORT_ARB_PERF_CNT_EN
    // Saturating performance counter next-values.
    always_comb begin
        perf_pause_d  = ((state_q == ST_PAUSE) && (perf_pause_q != '1)) ? perf_pause_q + 32'd1 : perf_pause_q;
        perf_late_sum = {1'b0, perf_late_q} + 33'(n_late_wr);
        perf_late_d   = perf_late_sum[32] ? '1 : perf_late_sum[31:0];
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_pause_q <= '0;
            perf_late_q  <= '0;
        end else begin
            perf_pause_q <= perf_pause_d;
            perf_late_q  <= perf_late_d;
        end
    end

    assign perf_pause_cycles_o = perf_pause_q;
    assign perf_late_writes_o  = perf_late_q;
`endif

endmodule

// File: tb/tb_wb_rf_wport_arbiter.sv
// Self-checking bench for wb_rf_wport_arbiter: queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_wb_rf_wport_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wb_we;
    logic [9:0]  wb_waddr;
    logic [63:0] wb_wdata;
    logic        late_valid;
    logic        late_ready;
    logic [4:0]  late_waddr;
    logic [31:0] late_wdata;
    logic [1:0]  rf_we;
    logic [9:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        pause_req;
    logic        busy;
`ifdef WPORT_ARB_PERF_CNT_EN
    logic [31:0] perf_pause;
    logic [31:0] perf_late;
`endif

    wb_rf_wport_arbiter #(
        .ISSUE_WIDTH(2),
        .WPORTS(2),
        .LATE_DEPTH(DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wb_we_i(wb_we),
        .wb_waddr_i(wb_waddr),
        .wb_wdata_i(wb_wdata),
        .late_valid_i(late_valid),
        .late_ready_o(late_ready),
        .late_waddr_i(late_waddr),
        .late_wdata_i(late_wdata),
        .rf_we_o(rf_we),
        .rf_waddr_o(rf_waddr),
        .rf_wdata_o(rf_wdata),
        .pause_req_o(pause_req),
        .busy_o(busy)
`ifdef WPORT_ARB_PERF_CNT_EN
       ,.perf_pause_cycles_o(perf_pause),
        .perf_late_writes_o(perf_late)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: late results as a queue, port picks from the rules.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    bit          m_pause;
    int          m_starve;
    logic [1:0]  e_we;
    logic [4:0]  e_addr [2];
    logic [31:0] e_data [2];
    logic [31:0] m_perf_pause;
    logic [31:0] m_perf_late;
    int          m_used, m_take, m_size0;
    bit          m_lv [2];
    logic [4:0]  m_la [2];
    logic [31:0] m_ld [2];
    ent_t        m_e;
    bit          m_hit;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_pause = 0;
            m_starve = 0;
            e_we = 2'b00;
            e_addr[0] = 0; e_addr[1] = 0;
            e_data[0] = 0; e_data[1] = 0;
            m_perf_pause = 0;
            m_perf_late = 0;
        end else begin
            m_la[0] = wb_waddr[4:0];  m_la[1] = wb_waddr[9:5];
            m_ld[0] = wb_wdata[31:0]; m_ld[1] = wb_wdata[63:32];
            e_we = 2'b00;
            m_used = 0;
            for (int i = 0; i < 2; i++) begin
                m_lv[i] = wb_we[i] && (m_la[i] != 0) && !m_pause;
                if (m_lv[i]) begin
                    e_we[m_used] = 1'b1;
                    e_addr[m_used] = m_la[i];
                    e_data[m_used] = m_ld[i];
                    m_used++;
                end
            end
            m_size0 = q.size();
            m_take = (2 - m_used < m_size0) ? 2 - m_used : m_size0;
            for (int k = 0; k < m_take; k++) begin
                m_e = q.pop_front();
                m_hit = (m_lv[0] && m_la[0] == m_e.a) || (m_lv[1] && m_la[1] == m_e.a);
                if (!m_hit) begin
                    e_we[m_used + k] = 1'b1;
                    e_addr[m_used + k] = m_e.a;
                    e_data[m_used + k] = m_e.d;
                    if (m_perf_late != 32'hFFFFFFFF) m_perf_late++;
                end
            end
            if (late_valid && m_size0 < DEPTH && late_waddr != 0) begin
                m_e.a = late_waddr;
                m_e.d = late_wdata;
                q.push_back(m_e);
            end
            if (m_pause) begin
                if (m_perf_pause != 32'hFFFFFFFF) m_perf_pause++;
                m_starve = 0;
                if (m_size0 == 0) m_pause = 0;
            end else if (m_starve >= LIMIT) begin
                m_pause = 1;
                m_starve = 0;
            end else if (m_size0 == 0 || m_take > 0) begin
                m_starve = 0;
            end else begin
                m_starve++;
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("m_we", {30'd0, rf_we}, {30'd0, e_we});
            chk("m_addr0", {27'd0, rf_waddr[4:0]}, {27'd0, e_addr[0]});
            chk("m_addr1", {27'd0, rf_waddr[9:5]}, {27'd0, e_addr[1]});
            chk("m_data0", rf_wdata[31:0], e_data[0]);
            chk("m_data1", rf_wdata[63:32], e_data[1]);
            chk("m_pause", {31'd0, pause_req}, {31'd0, m_pause});
            chk("m_ready", {31'd0, late_ready}, {31'd0, (q.size() < DEPTH)});
            chk("m_busy", {31'd0, busy}, {31'd0, (q.size() != 0)});
`ifdef WPORT_ARB_PERF_CNT_EN
            chk("m_perf_pause", perf_pause, m_perf_pause);
            chk("m_perf_late", perf_late, m_perf_late);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_we = 2'b00;
        late_valid = 1'b0;
    endtask

    task automatic lane(input bit i, input logic [4:0] a, input logic [31:0] d);
        if (!i) begin
            wb_we[0] = 1'b1; wb_waddr[4:0] = a; wb_wdata[31:0] = d;
        end else begin
            wb_we[1] = 1'b1; wb_waddr[9:5] = a; wb_wdata[63:32] = d;
        end
    endtask

    task automatic late(input logic [4:0] a, input logic [31:0] d);
        late_valid = 1'b1;
        late_waddr = a;
        late_wdata = d;
    endtask

    logic [4:0]  la_tab [3];
    logic [31:0] ld_tab [3];
    int li;
    bit acc;

    initial begin
        rst = 1'b1;
        idle();
        wb_waddr = '0; wb_wdata = '0; late_waddr = '0; late_wdata = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_we", {30'd0, rf_we}, 32'd0);
        chk("rst_addr", {22'd0, rf_waddr}, 32'd0);
        chk("rst_pause", {31'd0, pause_req}, 32'd0);
        chk("rst_ready", {31'd0, late_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Lanes only
        lane(0, 5'd3, 32'h11); lane(1, 5'd7, 32'h22);
        tick();
        chk("lanes_we", {30'd0, rf_we}, 32'd3);
        chk("lanes_a0", {27'd0, rf_waddr[4:0]}, 32'd3);
        chk("lanes_a1", {27'd0, rf_waddr[9:5]}, 32'd7);
        chk("lanes_d0", rf_wdata[31:0], 32'h11);
        chk("lanes_d1", rf_wdata[63:32], 32'h22);
        chk("lanes_ready", {31'd0, late_ready}, 32'd1);
        idle(); tick();

        // Late fill-in
        late(5'd9, 32'hAB);
        tick();
        chk("fill_busy_q", {31'd0, busy}, 32'd1);
        late_valid = 1'b0;
        lane(0, 5'd5, 32'h55);
        tick();
        chk("fill_we", {30'd0, rf_we}, 32'd3);
        chk("fill_a0", {27'd0, rf_waddr[4:0]}, 32'd5);
        chk("fill_a1", {27'd0, rf_waddr[9:5]}, 32'd9);
        chk("fill_d1", rf_wdata[63:32], 32'hAB);
        chk("fill_busy", {31'd0, busy}, 32'd0);
        idle(); tick();

        // FIFO full and starvation pause
        la_tab[0] = 5'd10; ld_tab[0] = 32'hA0;
        la_tab[1] = 5'd11; ld_tab[1] = 32'hB0;
        la_tab[2] = 5'd12; ld_tab[2] = 32'hC0;
        li = 0;
        for (int c = 0; c < 10; c++) begin
            lane(0, 5'd1, 32'h100 + c);
            lane(1, 5'd2, 32'h200 + c);
            if (li < 3) late(la_tab[li], ld_tab[li]);
            else late_valid = 1'b0;
            acc = late_valid && late_ready;
            tick();
            if (acc) li++;
            if (c == 1) begin
                chk("full_ready", {31'd0, late_ready}, 32'd0);
                chk("full_busy", {31'd0, busy}, 32'd1);
            end
            if (c == 4) chk("full_pause_lo", {31'd0, pause_req}, 32'd0);
            if (c == 5) chk("full_pause_hi", {31'd0, pause_req}, 32'd1);
            if (c == 6) begin
                chk("drain_we", {30'd0, rf_we}, 32'd3);
                chk("drain_a0", {27'd0, rf_waddr[4:0]}, 32'd10);
                chk("drain_d0", rf_wdata[31:0], 32'hA0);
                chk("drain_a1", {27'd0, rf_waddr[9:5]}, 32'd11);
                chk("drain_d1", rf_wdata[63:32], 32'hB0);
                chk("drain_busy", {31'd0, busy}, 32'd0);
                chk("drain_pause", {31'd0, pause_req}, 32'd1);
            end
            if (c == 7) begin
                chk("release_pause", {31'd0, pause_req}, 32'd0);
                chk("third_push_busy", {31'd0, busy}, 32'd1);
                chk("third_push_acc", li, 32'd3);
            end
        end
        idle();
        tick();
        chk("third_we", {30'd0, rf_we}, 32'd1);
        chk("third_a0", {27'd0, rf_waddr[4:0]}, 32'd12);
        chk("third_d0", rf_wdata[31:0], 32'hC0);
        chk("third_busy", {31'd0, busy}, 32'd0);
        tick();

        // Same-cycle WAW: lane wins, head discarded
        late(5'd4, 32'h1);
        tick();
        late_valid = 1'b0;
        lane(0, 5'd4, 32'h2);
        tick();
        chk("waw_we", {30'd0, rf_we}, 32'd1);
        chk("waw_a0", {27'd0, rf_waddr[4:0]}, 32'd4);
        chk("waw_d0", rf_wdata[31:0], 32'h2);
        chk("waw_busy", {31'd0, busy}, 32'd0);
        idle(); tick();

        // r0 writes dropped for both classes
        lane(0, 5'd0, 32'h33); lane(1, 5'd0, 32'h44);
        late(5'd0, 32'h55);
        tick();
        chk("r0_we", {30'd0, rf_we}, 32'd0);
        chk("r0_busy", {31'd0, busy}, 32'd0);
        chk("r0_ready", {31'd0, late_ready}, 32'd1);
        idle(); tick();

        // Reset with two entries queued while paused
        for (int c = 0; c < 6; c++) begin
            lane(0, 5'd1, 32'h300 + c);
            lane(1, 5'd2, 32'h400 + c);
            if (c < 2) late(5'(20 + c), 32'h500 + c);
            else late_valid = 1'b0;
            tick();
        end
        chk("pre_rst_pause", {31'd0, pause_req}, 32'd1);
        chk("pre_rst_ready", {31'd0, late_ready}, 32'd0);
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        chk("mid_rst_we", {30'd0, rf_we}, 32'd0);
        chk("mid_rst_addr", {22'd0, rf_waddr}, 32'd0);
        chk("mid_rst_data_lo", rf_wdata[31:0], 32'd0);
        chk("mid_rst_data_hi", rf_wdata[63:32], 32'd0);
        chk("mid_rst_pause", {31'd0, pause_req}, 32'd0);
        chk("mid_rst_ready", {31'd0, late_ready}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);

        // Mixed traffic, checked by the model only
        for (int c = 0; c < 80; c++) begin
            wb_we = 2'($urandom_range(0, 3));
            wb_waddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wb_wdata = {$urandom, $urandom};
            late_valid = 1'($urandom_range(0, 1));
            late_waddr = 5'($urandom_range(0, 7));
            late_wdata = $urandom;
            tick();
        end
        idle();
        for (int c = 0; c < 8; c++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
